cpu_sram_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the CPU instruction-fetch master and the data (load/store) master.
- Sits between the pipeline's inst/data SRAM-like interfaces and the downstream memory/bridge.
- Grants one transaction at a time, with data-side priority and a bounded-starvation guard for fetch.
- Locks the slave request until address handshake, then routes the response back to its owner.

---
 rtl/cpu_sram_arbiter.sv | 125 ++++++++++++
 tb/tb_cpu_sram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sram_arbiter.sv
// Arbiter that shares one SRAM-like slave port between the fetch and data masters.
// Data has priority; fetch is forced through after STARVE_LIMIT back-to-back data grants.
module cpu_sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic [1:0]  arb_owner
);

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;

  logic sel_d;     // 1: data master drives the slave, 0: fetch master
  logic req_raw;   // slave request before the reset gate
  logic hs;        // address handshake this cycle

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    sel_d    = (owner_q == OWN_D);
    req_raw  = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d   = !(i_req && (!d_req || starve_q == LIMIT));
        req_raw = i_req || d_req;
        if (req_raw) begin
          owner_d = sel_d ? OWN_D : OWN_I;
          state_d = s_addr_ok ? RESP : HOLD;
        end
      end
      HOLD: begin
        // Request stays locked to the owner until the slave takes it.
        req_raw = 1'b1;
        if (s_addr_ok) state_d = RESP;
      end
      RESP: begin
        if (s_data_ok) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    hs = req_raw && s_addr_ok;
    if (hs) begin
      if (sel_d && i_req)
        starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
      else
        starve_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign s_req   = req_raw && !reset;
  assign s_wr    = sel_d ? d_wr    : i_wr;
  assign s_size  = sel_d ? d_size  : i_size;
  assign s_addr  = sel_d ? d_addr  : i_addr;
  assign s_wdata = sel_d ? d_wdata : i_wdata;
  assign s_wstrb = sel_d ? d_wstrb : i_wstrb;

  assign i_addr_ok = !reset && hs && !sel_d;
  assign d_addr_ok = !reset && hs &&  sel_d;

  // Stray s_data_ok outside RESP never reaches a master.
  assign i_data_ok = !reset && (state_q == RESP) && (owner_q == OWN_I) && s_data_ok;
  assign d_data_ok = !reset && (state_q == RESP) && (owner_q == OWN_D) && s_data_ok;

  assign i_rdata   = s_rdata;
  assign d_rdata   = s_rdata;
  assign arb_owner = (state_q == IDLE) ? OWN_NONE : owner_q;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed bench: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
module tb_cpu_sram_arbiter;

  logic        clk, reset;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size, s_size, arb_owner;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, i_rdata, d_rdata;
  logic [3:0]  i_wstrb, d_wstrb, s_wstrb;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [31:0] s_addr, s_wdata, s_rdata;

  cpu_sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .arb_owner(arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  typedef struct { bit is_d; logic [70:0] f; } gnt_t;
  typedef struct { bit is_d; logic [31:0] rd; } rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2401_0001;
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Slave model: s_addr_ok after hold_cfg waiting cycles, s_data_ok resp_lat cycles after handshake.
  int          hold_cfg, resp_lat, wait_cnt, rcnt;
  logic        force_dok;
  logic [31:0] rdata_q;

  always @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 0;
      rcnt     <= 0;
    end else if (s_req && s_addr_ok) begin
      wait_cnt <= 0;
      rcnt     <= resp_lat;
      rdata_q  <= rd_of(s_addr);
    end else begin
      if (s_req) wait_cnt <= wait_cnt + 1;
      if (rcnt != 0) rcnt <= rcnt - 1;
    end
  end

  assign s_addr_ok = s_req && (wait_cnt >= hold_cfg);
  assign s_data_ok = (rcnt == 1) || force_dok;
  assign s_rdata   = rdata_q;

  // Monitor
  initial begin
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (s_req && s_addr_ok) begin
          hs_cnt++;
          if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
          else begin
            g = gq.pop_front();
            chk("gnt_who", {d_addr_ok, i_addr_ok}, g.is_d ? 2'b10 : 2'b01);
            chk("gnt_fields", {s_wr, s_size, s_addr, s_wdata, s_wstrb}, g.f);
          end
        end else if (i_addr_ok || d_addr_ok) begin
          chk("aok_spurious", {i_addr_ok, d_addr_ok}, 2'b00);
        end
        if (i_data_ok || d_data_ok) begin
          if (rq.size() == 0) chk("rsp_unexpected", {i_data_ok, d_data_ok}, 2'b00);
          else begin
            r = rq.pop_front();
            chk("rsp_who", {d_data_ok, i_data_ok}, r.is_d ? 2'b10 : 2'b01);
            chk("rsp_data", r.is_d ? d_rdata : i_rdata, r.rd);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic exp_txn(input bit is_d, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input bit resp);
    gnt_t g;
    rsp_t r;
    g.is_d = is_d; g.f = {wr, sz, a, wd, st};
    gq.push_back(g);
    if (resp) begin
      r.is_d = is_d; r.rd = rd_of(a);
      rq.push_back(r);
    end
  endtask

  task automatic set_i(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    i_wr = wr; i_size = sz; i_addr = a; i_wdata = wd; i_wstrb = st;
  endtask

  task automatic set_d(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    d_wr = wr; d_size = sz; d_addr = a; d_wdata = wd; d_wstrb = st;
  endtask

  // Raise one master's req and hold it until addr_ok, bounded.
  task automatic send(input bit is_d);
    bit got = 0;
    tick();
    if (is_d) d_req = 1'b1; else i_req = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = is_d ? d_addr_ok : i_addr_ok;
    end
    chk("send_aok_seen", got, 1);
    tick();
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 100 && (rq.size() != 0 || gq.size() != 0); n++) @(negedge clk);
    chk(nm, rq.size() + gq.size(), 0);
  endtask

  initial begin
    int base;
    reset = 1'b1; force_dok = 1'b0; hold_cfg = 0; resp_lat = 1;
    i_req = 1'b1; d_req = 1'b1;
    set_i(0, 2'd2, 32'h0, 32'h0, 4'hF);
    set_d(0, 2'd2, 32'h0, 32'h0, 4'hF);

    // Reset: outputs gated even with both masters requesting
    tick(); tick();
    @(negedge clk);
    chk("rst_s_req", s_req, 0);
    chk("rst_aok", {i_addr_ok, d_addr_ok}, 2'b00);
    chk("rst_owner", arb_owner, 2'b00);
    tick();
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // Fetch-only read, response 2 cycles after accept
    resp_lat = 2;
    set_i(0, 2'd2, 32'hBFC0_0000, 32'h0, 4'hF);
    exp_txn(0, 0, 2'd2, 32'hBFC0_0000, 32'h0, 4'hF, 1);
    tick(); i_req = 1'b1;
    @(negedge clk);
    chk("t1_i_aok", i_addr_ok, 1);
    chk("t1_d_aok", d_addr_ok, 0);
    tick(); i_req = 1'b0;
    @(negedge clk);
    chk("t1_early_dok", {i_data_ok, d_data_ok}, 2'b00);
    @(negedge clk);
    chk("t1_i_dok", i_data_ok, 1);
    chk("t1_i_rdata", i_rdata, 32'h2401_0001);
    @(negedge clk);
    chk("t1_owner_idle", arb_owner, 2'b00);
    drain("t1_drain");

    // Simultaneous requests: data first, fetch right after d_data_ok
    resp_lat = 1;
    set_i(0, 2'd2, 32'hBFC0_0010, 32'h0, 4'hF);
    set_d(0, 2'd2, 32'h0000_0200, 32'h0, 4'hF);
    exp_txn(1, 0, 2'd2, 32'h0000_0200, 32'h0, 4'hF, 1);
    exp_txn(0, 0, 2'd2, 32'hBFC0_0010, 32'h0, 4'hF, 1);
    tick(); i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk("t2_aok_c0", {d_addr_ok, i_addr_ok}, 2'b10);
    tick(); d_req = 1'b0;
    @(negedge clk);
    chk("t2_d_dok", d_data_ok, 1);
    chk("t2_i_wait", i_addr_ok, 0);
    @(negedge clk);
    chk("t2_i_aok", i_addr_ok, 1);
    tick(); i_req = 1'b0;
    drain("t2_drain");

    // HOLD: slave stalls 3 cycles, fetch rises mid-hold and must wait
    hold_cfg = 3;
    set_d(1, 2'd2, 32'h0000_1000, 32'hCAFE_F00D, 4'hF);
    set_i(0, 2'd2, 32'hBFC0_0004, 32'h0, 4'hF);
    exp_txn(1, 1, 2'd2, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 1);
    exp_txn(0, 0, 2'd2, 32'hBFC0_0004, 32'h0, 4'hF, 1);
    tick(); d_req = 1'b1;
    @(negedge clk);
    chk("t3_s_req", s_req, 1);
    chk("t3_d_aok_c0", d_addr_ok, 0);
    tick(); i_req = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      if (k == 2) @(negedge clk); else @(negedge clk);
      chk("t3_hold_owner", arb_owner, 2'b10);
      chk("t3_hold_fields", {s_wr, s_addr, s_wstrb}, {1'b1, 32'h0000_1000, 4'hF});
      chk("t3_hold_i_aok", i_addr_ok, 0);
    end
    @(negedge clk);
    chk("t3_d_aok", {d_addr_ok, i_addr_ok}, 2'b10);
    tick(); d_req = 1'b0; hold_cfg = 0;
    @(negedge clk);
    chk("t3_d_dok", d_data_ok, 1);
    chk("t3_i_still_wait", i_addr_ok, 0);
    @(negedge clk);
    chk("t3_i_aok", i_addr_ok, 1);
    tick(); i_req = 1'b0;
    drain("t3_drain");

    // Starvation guard: D,D,D,D,I,D,D,D,D,I with both requesting continuously
    set_i(0, 2'd2, 32'h0000_2000, 32'h0, 4'hF);
    set_d(0, 2'd2, 32'h0000_3000, 32'h0, 4'hF);
    for (int k = 0; k < 10; k++)
      if (k == 4 || k == 9) exp_txn(0, 0, 2'd2, 32'h0000_2000, 32'h0, 4'hF, 1);
      else                  exp_txn(1, 0, 2'd2, 32'h0000_3000, 32'h0, 4'hF, 1);
    base = hs_cnt;
    tick(); i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 200 && hs_cnt < base + 10; n++) @(negedge clk);
    tick(); i_req = 1'b0; d_req = 1'b0;
    chk("t4_grants", hs_cnt - base, 10);
    drain("t4_drain");

    // Data write passes through unchanged
    set_d(1, 2'd1, 32'h1FAF_0000, 32'h0000_BEEF, 4'b0011);
    exp_txn(1, 1, 2'd1, 32'h1FAF_0000, 32'h0000_BEEF, 4'b0011, 1);
    send(1);
    drain("t5_drain");

    // Reset in RESP: response dropped, later stray s_data_ok ignored
    resp_lat = 5;
    set_i(0, 2'd2, 32'h0000_4000, 32'h0, 4'hF);
    exp_txn(0, 0, 2'd2, 32'h0000_4000, 32'h0, 4'hF, 0);
    send(0);
    @(negedge clk);
    chk("t6_in_resp", arb_owner, 2'b01);
    tick(); reset = 1'b1; i_req = 1'b1;
    @(negedge clk);
    chk("t6_rst_s_req", s_req, 0);
    chk("t6_rst_i_aok", i_addr_ok, 0);
    @(negedge clk);
    chk("t6_rst_owner", arb_owner, 2'b00);
    tick(); reset = 1'b0; i_req = 1'b0; force_dok = 1'b1;
    @(negedge clk);
    chk("t6_stray_dok", {i_data_ok, d_data_ok}, 2'b00);
    chk("t6_owner", arb_owner, 2'b00);
    tick(); force_dok = 1'b0;
    @(negedge clk);
    chk("t6_idle", {arb_owner, s_req}, 3'b000);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
